// File: rtl/alarm_clk_ram_ctrl.sv
// Avalon-MM slave front-end for a 2048x32 single-port on-chip RAM with 1-cycle read latency.
// Define ALARM_CLK_RAM_CTRL_CLEAR_EN to sweep CLEAR_VALUE through the whole RAM after reset.
`timescale 1ns/1ps
module alarm_clk_ram_ctrl #(
    parameter int                ADDR_W      = 11,
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req,
    input  logic [ADDR_W-1:0]   avs_address,
    input  logic [DATA_W/8-1:0] avs_byteenable,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [DATA_W-1:0]   avs_writedata,
    output logic [DATA_W-1:0]   avs_readdata,
    output logic                avs_readdatavalid,
    output logic                avs_waitrequest,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata,
    output logic                init_done,
    output logic                protocol_err
);

    logic              w_busy;
    logic              w_accept;
    logic              w_rdAccept;
    logic              w_clearWrite;
    logic [ADDR_W-1:0] w_clearAddr;
    logic              r_rdValid;
    logic              r_protoErr;

`ifdef ALARM_CLK_RAM_CTRL_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_clearCnt;
    logic [ADDR_W-1:0] w_nextCnt;
    logic              r_initDone;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_INIT;
            r_clearCnt <= '0;
            r_initDone <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_clearCnt <= w_nextCnt;
            r_initDone <= (w_nextState == S_RUN);
        end
    end

    // The sweep only advances on cycles where reset_req is low, so a pause resumes at the same address.
    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = r_clearCnt;
        w_clearWrite = 1'b0;
        if (r_state == S_INIT && !reset_req) begin
            w_clearWrite = 1'b1;
            if (r_clearCnt == LAST_ADDR) begin
                w_nextState = S_RUN;
            end else begin
                w_nextCnt = r_clearCnt + 1'b1;
            end
        end
    end

    assign w_busy      = (r_state != S_RUN);
    assign w_clearAddr = r_clearCnt;
    assign init_done   = r_initDone;
`else
    // Without the sweep the RAM is usable as soon as reset is released.
    assign w_busy       = reset;
    assign w_clearWrite = 1'b0;
    assign w_clearAddr  = '0;
    assign init_done    = ~reset;
`endif

    assign avs_waitrequest = w_busy | reset_req;
    assign w_accept        = (avs_read | avs_write) & ~avs_waitrequest;
    assign w_rdAccept      = w_accept & avs_read & ~avs_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdValid  <= 1'b0;
            r_protoErr <= 1'b0;
        end else begin
            r_rdValid  <= w_rdAccept;
            r_protoErr <= r_protoErr | (avs_read & avs_write);
        end
    end

    always_comb begin
        ram_address    = avs_address;
        ram_byteenable = avs_byteenable;
        ram_writedata  = avs_writedata;
        ram_chipselect = w_accept;
        ram_write      = w_accept & avs_write;
        if (w_clearWrite) begin
            ram_address    = w_clearAddr;
            ram_byteenable = '1;
            ram_writedata  = CLEAR_VALUE;
            ram_chipselect = 1'b1;
            ram_write      = 1'b1;
        end
    end

    assign ram_clken         = ~reset_req;
    assign avs_readdatavalid = r_rdValid;
    assign avs_readdata      = r_rdValid ? ram_readdata : '0;
    assign protocol_err      = r_protoErr;

endmodule
